// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: holds the PLL in reset, waits for a stable
// synchronized lock, stretches the system reset, then runs. Repeated
// acquisition timeouts end in FAULT, or in BYPASS when the optional
// fallback is built in.
// Optional feature macro: PLL_BYPASS_FALLBACK_EN (BYPASS fallback).
// STATE encoding: HOLD=0, ACQUIRE=1, STRETCH=2, RUN=3, FAULT=4, BYPASS=5.
module pll_reset_sequencer #(
  parameter int RESET_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES    = 64,
  parameter int LOCK_TIMEOUT_CYCLES   = 4096,
  parameter int SYSRST_STRETCH_CYCLES = 16,
  parameter int MAX_RETRIES           = 3
) (
  input  logic       REFERENCECLK,
  input  logic       RESET,
  input  logic       PLL_LOCK,
  input  logic       RELOCK_REQ,
  output logic       PLL_RESETB,
  output logic       PLL_BYPASS,
  output logic       SYS_RESET_N,
  output logic       READY,
  output logic       FAULT,
  output logic [3:0] RETRY_COUNT,
  output logic [2:0] STATE
);

  typedef enum logic [2:0] {
    S_HOLD    = 3'd0,
    S_ACQUIRE = 3'd1,
    S_STRETCH = 3'd2,
    S_RUN     = 3'd3,
    S_FAULT   = 3'd4,
    S_BYPASS  = 3'd5
  } state_t;

  localparam int MAX_HT  = (RESET_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                           RESET_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_SS  = (LOCK_STABLE_CYCLES > SYSRST_STRETCH_CYCLES) ?
                           LOCK_STABLE_CYCLES : SYSRST_STRETCH_CYCLES;
  localparam int MAX_ALL = (MAX_HT > MAX_SS) ? MAX_HT : MAX_SS;
  localparam int CW      = $clog2(MAX_ALL + 1);

  localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(SYSRST_STRETCH_CYCLES - 1);
  localparam logic [3:0]    TRIES_LIMIT  = 4'(MAX_RETRIES);

`ifdef PLL_BYPASS_FALLBACK_EN
  localparam logic [CW-1:0] STRETCH_FULL = CW'(SYSRST_STRETCH_CYCLES);
  localparam state_t        GIVEUP_STATE = S_BYPASS;
`else
  localparam state_t        GIVEUP_STATE = S_FAULT;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;        // cycles spent in the current state
  logic [CW-1:0] stable_q, stable_d;  // consecutive synchronized-lock-high cycles
  logic [3:0]    consec_q, consec_d;  // consecutive acquisition timeouts
  logic [3:0]    retry_q, retry_d;
  logic [3:0]    retry_bump;
  logic          sync1_q, sync2_q;
  logic          lock_s;

  logic pll_resetb_d, pll_bypass_d, sys_reset_n_d, ready_d, fault_d;

  assign lock_s      = sync2_q;
  assign retry_bump  = (retry_q == 4'd15) ? retry_q : retry_q + 4'd1;
  assign STATE       = state_q;
  assign RETRY_COUNT = retry_q;

  // Two-flop lock synchronizer; cleared while the PLL is held in reset so
  // every attempt starts from a fresh, trusted lock observation.
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else if (state_q == S_HOLD) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= PLL_LOCK;
      sync2_q <= sync1_q;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge REFERENCECLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_HOLD;
      cnt_q       <= '0;
      stable_q    <= '0;
      consec_q    <= '0;
      retry_q     <= '0;
      PLL_RESETB  <= 1'b0;
      PLL_BYPASS  <= 1'b0;
      SYS_RESET_N <= 1'b0;
      READY       <= 1'b0;
      FAULT       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stable_q    <= stable_d;
      consec_q    <= consec_d;
      retry_q     <= retry_d;
      PLL_RESETB  <= pll_resetb_d;
      PLL_BYPASS  <= pll_bypass_d;
      SYS_RESET_N <= sys_reset_n_d;
      READY       <= ready_d;
      FAULT       <= fault_d;
    end
  end

  // Next-state, counter updates and output decode of the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    stable_d = '0;
    consec_d = consec_q;
    retry_d  = retry_q;

    case (state_q)
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_ACQUIRE;
          cnt_d   = '0;
        end
      end
      S_ACQUIRE: begin
        stable_d = lock_s ? stable_q + CW'(1) : '0;
        // Accepting lock takes priority over a timeout on the same cycle.
        if (lock_s && (stable_q == STABLE_LAST)) begin
          state_d  = S_STRETCH;
          cnt_d    = '0;
          stable_d = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          consec_d = consec_q + 4'd1;
          retry_d  = retry_bump;
          cnt_d    = '0;
          stable_d = '0;
          state_d  = ((consec_q + 4'd1) == TRIES_LIMIT) ? GIVEUP_STATE : S_HOLD;
        end
      end
      S_STRETCH: begin
        if (!lock_s) begin
          state_d = S_HOLD;
          retry_d = retry_bump;
          cnt_d   = '0;
        end else if (cnt_q == STRETCH_LAST) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        cnt_d    = '0;
        consec_d = '0;
        // Lock loss and relock together still count as one lost lock.
        if (!lock_s) begin
          state_d = S_HOLD;
          retry_d = retry_bump;
        end else if (RELOCK_REQ) begin
          state_d = S_HOLD;
        end
      end
      S_FAULT: begin
        cnt_d = '0;
        if (RELOCK_REQ) begin
          state_d  = S_HOLD;
          consec_d = '0;
        end
      end
`ifdef PLL_BYPASS_FALLBACK_EN
      S_BYPASS: begin
        cnt_d = (cnt_q == STRETCH_FULL) ? cnt_q : cnt_q + CW'(1);
        if (RELOCK_REQ) begin
          state_d  = S_HOLD;
          consec_d = '0;
          cnt_d    = '0;
        end
      end
`endif
      default: begin
        state_d = S_HOLD;
        cnt_d   = '0;
      end
    endcase

    pll_resetb_d  = (state_d == S_ACQUIRE) || (state_d == S_STRETCH) ||
                    (state_d == S_RUN) || (state_d == S_BYPASS);
    pll_bypass_d  = (state_d == S_BYPASS);
    ready_d       = (state_d == S_RUN);
    fault_d       = (state_d == S_FAULT) || (state_d == S_BYPASS);
`ifdef PLL_BYPASS_FALLBACK_EN
    sys_reset_n_d = (state_d == S_RUN) ||
                    ((state_d == S_BYPASS) && (cnt_d == STRETCH_FULL));
`else
    sys_reset_n_d = (state_d == S_RUN);
`endif
  end

endmodule
